// File: rtl/reg8_rr_write_arbiter.sv
// reg8_rr_write_arbiter
// Round-robin write arbiter in front of a shared W-bit data register.
// Each cycle one valid requester is granted (one-hot, combinational req_ready).
// The granted data is loaded into q on the next rising edge, and the write is
// reported through q_owner, q_wr and wr_count.
//
// Optional feature macro: LOCK_EN
//   defined   : a requester granted with req_lock=1 keeps the grant while it
//               stays valid. Locked grants do not advance the round-robin pointer.
//   undefined : pure round-robin. req_lock is accepted but ignored.
module reg8_rr_write_arbiter #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             hold,
  input  logic [N-1:0]     req_valid,
  input  logic [N*W-1:0]   req_data,
  input  logic [N-1:0]     req_lock,
  output logic [N-1:0]     req_ready,
  output logic [W-1:0]     q,
  output logic [2:0]       q_owner,
  output logic             q_wr,
  output logic [CNT_W-1:0] wr_count
);

  // Requester indices are kept 3 bits wide everywhere, which covers N up to 8.
  logic [2:0]       r_rr_ptr;
  logic             r_lock_active;

  logic [2*N-1:0]   w_dbl_valid;
  logic [2:0]       w_rr_pos;
  logic [3:0]       w_rr_sum;
  logic [2:0]       w_rr_g;
  logic [2:0]       w_g;
  logic [2:0]       w_next_ptr;
  logic             w_any_valid;
  logic             w_owner_valid;
  logic             w_lock_hit;
  logic             w_grant;
  logic             w_grant_lock;
  logic [W-1:0]     w_data;
  logic [N-1:0]     w_one;

  assign w_one = {{(N-1){1'b0}}, 1'b1};

  // Round-robin pick: rotate the valid vector so rr_ptr lands at bit 0, then
  // take the lowest set bit and map the offset back to a requester index.
  always_comb begin
    w_dbl_valid = {req_valid, req_valid} >> r_rr_ptr;
    w_rr_pos    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_dbl_valid[k]) w_rr_pos = 3'(k);
    end
    w_rr_sum = {1'b0, r_rr_ptr} + {1'b0, w_rr_pos};
    if (w_rr_sum >= 4'(N)) w_rr_sum = w_rr_sum - 4'(N);
    w_rr_g = w_rr_sum[2:0];
  end

  // Final grant decision, including the optional lock override.
  always_comb begin
    w_any_valid   = |req_valid;
    w_owner_valid = |(req_valid & (w_one << q_owner));
`ifdef LOCK_EN
    w_lock_hit    = r_lock_active & w_owner_valid;
`else
    w_lock_hit    = 1'b0;
`endif
    w_grant       = resetn & ~hold & w_any_valid;
    w_g           = w_lock_hit ? q_owner : w_rr_g;
    req_ready     = w_grant ? (w_one << w_g) : '0;
    w_next_ptr    = (w_g == 3'(N - 1)) ? 3'd0 : (w_g + 3'd1);
  end

`ifdef LOCK_EN
  assign w_grant_lock = |(req_lock & req_ready);
`else
  // The lock request has no effect in this build; the port is kept for a
  // uniform interface across both configurations.
  logic w_unused_lock;
  assign w_unused_lock = |req_lock;
  assign w_grant_lock  = 1'b0;
`endif

  // Mux out the granted requester's data; other requesters' data is never looked at.
  always_comb begin
    w_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_g == 3'(i)) w_data = req_data[i*W +: W];
    end
  end

  // Shared register, write reporting, round-robin pointer and lock state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q             <= '0;
      q_owner       <= '0;
      q_wr          <= 1'b0;
      wr_count      <= '0;
      r_rr_ptr      <= '0;
      r_lock_active <= 1'b0;
    end else begin
      q_wr <= w_grant;
      if (w_grant) begin
        q             <= w_data;
        q_owner       <= w_g;
        wr_count      <= wr_count + 1'b1;
        r_lock_active <= w_grant_lock;
        if (!w_lock_hit) r_rr_ptr <= w_next_ptr;
      end else if (!hold) begin
        // Nothing is valid, so any held lock has lost its owner.
        r_lock_active <= 1'b0;
      end
    end
  end

endmodule
